// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_t;

  // Quotient delivered on division by zero; wide enough for any supported WIDTH,
  // users slice off the low WIDTH bits.
  localparam int                      MD_MAX_WIDTH = 128;
  localparam logic [MD_MAX_WIDTH-1:0] DIVZERO_QUOT = '1;

  function automatic logic md_is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate: result = negate ? -value : value.
// Used for operand magnitudes on entry and for sign correction of results.
module md_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] inv;

  // Bitwise conditional inversion; the +1 of the negate is added below.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_inv
      assign inv[gi] = value[gi] ^ negate;
    end
  endgenerate

  assign result = inv + {{(WIDTH-1){1'b0}}, negate};

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle multiply/divide unit (MULT, MULTU, DIV, DIVU) producing HI/LO.
// Sign-magnitude datapath: operands are made positive on entry, WIDTH
// shift-add or restoring shift-subtract iterations run, then one cycle
// restores the result signs. Outputs are registered when leaving DONE.
// Optional macro MDU_EARLY_TERM_EN: multiply by zero and divide by zero
// bypass RUN/FIX and complete in two cycles with identical results.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Decoded request
  md_op_t           op_in;
  logic             in_div;
  logic             in_signed;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign op_in     = md_op_t'(op);
  assign in_div    = md_is_div(op_in);
  assign in_signed = md_is_signed(op_in);
  assign sign_a    = in_signed & a[WIDTH-1];
  assign sign_b    = in_signed & b[WIDTH-1];

  // |0x80..0| comes out as the unsigned value 2^(WIDTH-1), which fits.
  md_sign_fix #(.WIDTH(WIDTH)) u_mag_a (.value(a), .negate(sign_a), .result(mag_a));
  md_sign_fix #(.WIDTH(WIDTH)) u_mag_b (.value(b), .negate(sign_b), .result(mag_b));

  // State
  md_state_t          state_reg;
  logic [CW-1:0]      cnt_reg;
  // Multiply: {partial product high, multiplier shifting out}.
  // Divide:   {remainder, dividend shifting out / quotient shifting in}.
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   opnd_reg;     // multiplicand or divisor magnitude
  logic               div_reg;
  logic               neg_res_reg;  // negate product / quotient
  logic               neg_rem_reg;  // negate remainder
  logic               dz_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               div_zero_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;

  // One iteration
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] step_next;

  // Next accumulator value for one shift-add or restoring shift-subtract step.
  always_comb begin
    add_sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    trial   = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]} - {1'b0, opnd_reg};
    step_next = {add_sum, acc_reg[WIDTH-1:1]};
    if (div_reg) begin
      if (!trial[WIDTH]) begin
        step_next = {trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
      end else begin
        step_next = {acc_reg[2*WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign correction: product and quotient share one full-width negator,
  // the remainder gets its own since it follows the dividend sign only.
  logic [2*WIDTH-1:0] fix_in;
  logic [2*WIDTH-1:0] fix_out;
  logic [WIDTH-1:0]   rem_fix;
  logic [2*WIDTH-1:0] fix_result;

  assign fix_in = div_reg ? {{WIDTH{1'b0}}, acc_reg[WIDTH-1:0]} : acc_reg;

  md_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
    .value(fix_in), .negate(neg_res_reg), .result(fix_out)
  );
  md_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
    .value(acc_reg[2*WIDTH-1:WIDTH]), .negate(neg_rem_reg), .result(rem_fix)
  );

  // With a zero divisor the remainder path reproduces the dividend exactly,
  // so only the quotient needs overriding.
  assign fix_result = div_reg
                    ? {rem_fix, (dz_reg ? DIVZERO_QUOT[WIDTH-1:0] : fix_out[WIDTH-1:0])}
                    : fix_out;

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= MD_IDLE;
      cnt_reg      <= '0;
      acc_reg      <= '0;
      opnd_reg     <= '0;
      div_reg      <= 1'b0;
      neg_res_reg  <= 1'b0;
      neg_rem_reg  <= 1'b0;
      dz_reg       <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
    end else begin
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
      case (state_reg)
        MD_IDLE: begin
          if (start) begin
            div_reg     <= in_div;
            neg_res_reg <= sign_a ^ sign_b;
            neg_rem_reg <= in_div & sign_a;
            dz_reg      <= in_div && (b == '0);
            opnd_reg    <= in_div ? mag_b : mag_a;
            acc_reg     <= {{WIDTH{1'b0}}, (in_div ? mag_a : mag_b)};
            cnt_reg     <= '0;
            state_reg   <= MD_RUN;
            busy_reg    <= 1'b1;
`ifdef MDU_EARLY_TERM_EN
            if (!in_div && ((a == '0) || (b == '0))) begin
              acc_reg   <= '0;
              state_reg <= MD_DONE;
              busy_reg  <= 1'b0;
            end else if (in_div && (b == '0)) begin
              acc_reg   <= {a, DIVZERO_QUOT[WIDTH-1:0]};
              state_reg <= MD_DONE;
              busy_reg  <= 1'b0;
            end
`endif
          end
        end
        MD_RUN: begin
          acc_reg <= step_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(WIDTH - 1)) begin
            state_reg <= MD_FIX;
          end
        end
        MD_FIX: begin
          acc_reg   <= fix_result;
          state_reg <= MD_DONE;
          busy_reg  <= 1'b0;
        end
        MD_DONE: begin
          done_reg     <= 1'b1;
          div_zero_reg <= dz_reg;
          hi_reg       <= acc_reg[2*WIDTH-1:WIDTH];
          lo_reg       <= acc_reg[WIDTH-1:0];
          state_reg    <= MD_IDLE;
        end
        default: state_reg <= MD_IDLE;
      endcase
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign div_zero = div_zero_reg;
  assign hi       = hi_reg;
  assign lo       = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO/div_zero
// and latency, a monitor pops and compares on every done pulse.
module tb_mult_div_unit;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 2;   // edges from start edge to the edge raising done
`ifdef MDU_EARLY_TERM_EN
  localparam int ET_LAT = 1;
`else
  localparam int ET_LAT = WIDTH + 2;
`endif

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [1:0]       op    = 2'd0;
  logic [WIDTH-1:0] a     = '0;
  logic [WIDTH-1:0] b     = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  mult_div_unit #(.WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dz;
    int               start_cyc;
    int               lat;
    string            name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got hi=%h lo=%h, no operation outstanding", hi, lo);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks += 4;
        if (hi !== e.hi) begin
          errors++;
          $display("FAIL %s.hi: got %h, expected %h", e.name, hi, e.hi);
        end
        if (lo !== e.lo) begin
          errors++;
          $display("FAIL %s.lo: got %h, expected %h", e.name, lo, e.lo);
        end
        if (div_zero !== e.dz) begin
          errors++;
          $display("FAIL %s.div_zero: got %b, expected %b", e.name, div_zero, e.dz);
        end
        if ((cyc - e.start_cyc) != e.lat) begin
          errors++;
          $display("FAIL %s.latency: got %0d edges, expected %0d", e.name, cyc - e.start_cyc, e.lat);
        end
        $display("txn %s: hi=%h lo=%h div_zero=%b latency=%0d", e.name, hi, lo, div_zero, cyc - e.start_cyc);
      end
    end
  end

  task automatic check1(input string nm, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Drive one start pulse; optionally register the expected response.
  task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic [WIDTH-1:0] ehi, input logic [WIDTH-1:0] elo, input logic edz,
                       input int elat, input string nm, input bit push);
    exp_t e;
    @(negedge clock);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clock);
    #1;
    start = 1'b0; op = ~o; a = $urandom; b = $urandom;
    if (push) begin
      e.hi = ehi; e.lo = elo; e.dz = edz; e.start_cyc = cyc; e.lat = elat; e.name = nm;
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    int busy_bad;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check1("reset.busy", {31'd0, busy}, 32'd0);
    check1("reset.done", {31'd0, done}, 32'd0);
    check1("reset.div_zero", {31'd0, div_zero}, 32'd0);
    check1("reset.hi", hi, 32'd0);
    check1("reset.lo", lo, 32'd0);
    reset = 1'b0;

    // MULTU all-ones, with busy profile checked edge by edge
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, LAT, "multu_ones", 1'b1);
    busy_bad = 0;
    for (int d = 0; d <= LAT; d++) begin
      if (d > 0) @(posedge clock);
      #2;
      if (busy !== ((d <= WIDTH) ? 1'b1 : 1'b0)) busy_bad++;
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL busy_profile: got %0d wrong cycles, expected 0", busy_bad);
    end
    wait_drain();

    issue(OP_MULT, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0, LAT, "mult_neg7x6", 1'b1);
    wait_drain();
    issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, LAT, "mult_minsq", 1'b1);
    wait_drain();
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, LAT, "div_neg7by2", 1'b1);
    wait_drain();
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, LAT, "div_7byneg2", 1'b1);
    wait_drain();
    issue(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, LAT, "divu_100by7", 1'b1);
    wait_drain();
    issue(OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1, ET_LAT, "divu_by0", 1'b1);
    wait_drain();
    issue(OP_DIV, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1, ET_LAT, "div_neg8by0", 1'b1);
    wait_drain();
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, LAT, "div_overflow", 1'b1);
    wait_drain();
    issue(OP_MULT, 32'd0, 32'd123, 32'd0, 32'd0, 1'b0, ET_LAT, "mult_zero", 1'b1);
    wait_drain();

    // Second start mid-RUN must be ignored
    issue(OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0, LAT, "multu_ignore2nd", 1'b1);
    repeat (5) @(negedge clock);
    start = 1'b1; op = OP_DIVU; a = 32'd5; b = 32'd0;
    @(negedge clock);
    start = 1'b0;
    wait_drain();
    repeat (5) @(negedge clock);

    // Reset at RUN iteration 10 aborts with no done
    issue(OP_DIVU, 32'hDEAD_BEEF, 32'd3, 32'd0, 32'd0, 1'b0, LAT, "aborted", 1'b0);
    repeat (10) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check1("abort.busy", {31'd0, busy}, 32'd0);
    check1("abort.done", {31'd0, done}, 32'd0);
    check1("abort.hi", hi, 32'd0);
    check1("abort.lo", lo, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (45) @(negedge clock);

    // Unit still works after the abort
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, LAT, "divu_after_abort", 1'b1);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multicycle multiply/divide unit for the MIPS datapath. Serves MULT, MULTU, DIV and DIVU.
- Sits downstream of the A/B operand registers, in parallel with the ALU. Consumes A register and B register contents.
- Produces HI/LO results, which the control unit later writes to the register bank via MFHI/MFLO.
- Control unit pulses start, then stalls in a wait state until done.

Parameters:
- WIDTH, 32, operand width in bits. HI and LO are each WIDTH bits.

Ports:
- clock  input  1  system clock
- reset  input  1  reset (see Behaviour)
- start  input  1  one-cycle request; sampled only in IDLE
- op  input  2  operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- a  input  WIDTH  operand A (multiplicand/dividend)
- b  input  WIDTH  operand B (multiplier/divisor)
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle completion pulse
- hi  output  WIDTH  product upper half / remainder
- lo  output  WIDTH  product lower half / quotient
- div_zero  output  1  pulses with done when a DIV/DIVU had b==0

Interface decision (already decided): one clock, named clock. Reset is named reset and is synchronous, active-high.

Behaviour:
- Reset, synchronous active-high: state=IDLE. busy=0, done=0, div_zero=0, hi=0, lo=0, all internal registers cleared.
- Reset asserted mid-operation aborts the operation and gives the same reset values. No done pulse is produced.
- State machine: IDLE -> RUN -> FIX -> DONE -> IDLE.
- IDLE:
  - start=1 latches op, a and b on that edge, then moves to RUN with the iteration counter = 0.
  - Signed ops (MULT, DIV) latch |a| and |b| and record the result signs.
- RUN:
  - One iteration per cycle; the counter increments each cycle.
  - Leaves RUN after exactly WIDTH iterations.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, with WIDTH-bit remainder and quotient.
- FIX (1 cycle): applies two's-complement negation where required.
  - Product: negated if sign(a) XOR sign(b).
  - Quotient: negated if sign(a) XOR sign(b).
  - Remainder: takes the sign of the dividend.
- DONE (1 cycle):
  - done=1; hi/lo registered with the final values; div_zero valid.
  - Returns to IDLE.
- Latency: start sampled at edge k gives busy=1 from edge k through the cycle before DONE. done=1 in the cycle after edge k+WIDTH+2.
- busy is 0 in IDLE and DONE.
- hi/lo hold their values until the next DONE or reset.
- start while busy or in DONE is ignored. There is no queueing.
- Arithmetic rules:
  - MULTU: {hi,lo} = a*b, unsigned.
  - MULT: {hi,lo} = signed a * signed b, full 2*WIDTH result.
  - DIVU: lo = a/b, hi = a%b.
  - DIV: quotient truncates toward zero; remainder has the dividend's sign.
- Division by zero (DIV or DIVU, b==0):
  - No trap. lo = all ones, hi = a unmodified.
  - div_zero=1 with done.
  - Same latency as a normal divide.
- Signed overflow: DIV with a=0x80000000, b=0xFFFFFFFF gives lo=0x80000000, hi=0. div_zero=0.
- Most-negative operand: |0x80000000| is handled as the unsigned value 2^31. No overflow occurs in the magnitude datapath.
- a and b may change after the start cycle without affecting the result.

Optional Feature:
- Macro: MDU_EARLY_TERM_EN.
- Defined:
  - Multiply with a==0 or b==0 skips RUN and FIX: IDLE -> DONE with hi=lo=0.
  - done=1 in the cycle after the edge following the start edge, i.e. 2-cycle latency.
  - Divide with b==0 takes the same shortcut with the div-by-zero values.
- Undefined: all operations use the fixed WIDTH+3 latency. Results are identical either way.

Decomposition:
- Package mdu_pkg:
  - md_op_t enum {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}
  - md_state_t enum {MD_IDLE, MD_RUN, MD_FIX, MD_DONE}
  - localparam DIVZERO_QUOT = all ones
- Sub-module md_sign_fix: combinational conditional two's-complement negate of a WIDTH-bit value. Used for operand magnitude in IDLE and for result correction in FIX.

Test Plan:
- MULTU, a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. done exactly 35 cycles after the start edge; busy high throughout RUN/FIX.
- MULT, a=-7 (0xFFFFFFF9), b=6 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6. div_zero=0.
- DIV, a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIV by zero:
  - DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100, div_zero=1 with done.
  - DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- start pulsed again mid-RUN with different operands -> ignored; first result delivered unchanged. Reset asserted at RUN iteration 10 -> next cycle busy=0, hi=lo=0, no done.
- With MDU_EARLY_TERM_EN: MULT a=0, b=123 -> done 2 cycles after start, hi=lo=0. Without the macro -> same values at 35 cycles.
